// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 serial target with display RAM, display control and key-scan readback
module tm1638_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        stb,
  input  logic        dio_in,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic [31:0] key_in,
  input  logic [3:0]  ram_raddr,
  output logic [7:0]  ram_rdata,
  output logic        display_on,
  output logic [2:0]  brightness,
  output logic        frame_done
);
  typedef enum logic [2:0] {IDLE, CMD, DATA, IGNORE, READ} state_t;
  state_t state, next;
  logic [1:0] sclk_s, stb_s, dio_s;
  logic sclk_d, stb_d;
  logic rise, fall, stb_rise, stb_fall, byte_done;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, b;
  logic [3:0] addr;
  logic fixed, dirty;
  logic [31:0] key_sr;
  logic [7:0] ram [16];
  // Synchronizers run through reset so edges seen after release are real pin edges
  always_ff @(posedge clk) begin
    sclk_s <= {sclk_s[0], sclk};
    stb_s  <= {stb_s[0], stb};
    dio_s  <= {dio_s[0], dio_in};
    sclk_d <= sclk_s[1];
    stb_d  <= stb_s[1];
  end
  assign stb_rise  = stb_s[1] & ~stb_d;
  assign stb_fall  = ~stb_s[1] & stb_d;
  assign rise      = sclk_s[1] & ~sclk_d & ~stb_rise;
  assign fall      = ~sclk_s[1] & sclk_d & ~stb_rise;
  assign b         = {dio_s[1], shreg[7:1]};
  assign byte_done = rise && bit_cnt == 3'd7 && (state == CMD || state == DATA);
  always_comb begin
    next = state;
    if (stb_rise) next = IDLE;
    else if (stb_fall) next = CMD;
    else if (state == CMD && byte_done)
      next = b[7:6] == 2'b11 ? DATA : (b[7:6] == 2'b01 && b[1]) ? READ : IGNORE;
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : next;
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      addr       <= '0;
      fixed      <= 1'b0;
      dirty      <= 1'b0;
      key_sr     <= '0;
      dio_out    <= 1'b1;
      dio_oe     <= 1'b0;
      display_on <= 1'b0;
      brightness <= '0;
      frame_done <= 1'b0;
      ram_rdata  <= '0;
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else begin
      frame_done <= stb_rise & dirty;
      ram_rdata  <= ram[ram_raddr];
      if (stb_fall) begin
        bit_cnt <= '0;
        dirty   <= 1'b0;
      end
      if (stb_rise) begin
        dio_oe  <= 1'b0;
        dio_out <= 1'b1;
      end
      if (rise && (state == CMD || state == DATA)) begin
        shreg   <= b;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done && state == CMD) begin
        if (b[7:6] == 2'b01) begin
          fixed  <= b[2];
          key_sr <= key_in;
        end
        if (b[7:6] == 2'b10) begin
          display_on <= b[3];
          brightness <= b[2:0];
        end
        if (b[7:6] == 2'b11) addr <= b[3:0];
      end
      if (byte_done && state == DATA) begin
        ram[addr] <= b;
        dirty     <= 1'b1;
        if (!fixed) addr <= addr + 4'd1;
      end
      // Zeros shift in behind the snapshot, so bits past 32 read as 0
      if (fall && state == READ) begin
        dio_oe  <= 1'b1;
        dio_out <= key_sr[0];
        key_sr  <= {1'b0, key_sr[31:1]};
      end
    end
  end
endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: directed pin-level initiator checks for tm1638_responder
module tb_tm1638_responder;
  logic clk = 1'b0;
  logic rst, sclk, stb, dio_in, dio_out, dio_oe, display_on, frame_done;
  logic [31:0] key_in;
  logic [3:0] ram_raddr;
  logic [7:0] ram_rdata, v;
  logic [2:0] brightness;
  int checks = 0, errors = 0, fd_cnt = 0, base;

  tm1638_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .stb(stb), .dio_in(dio_in),
    .dio_out(dio_out), .dio_oe(dio_oe), .key_in(key_in),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .display_on(display_on),
    .brightness(brightness), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; dio_in = d[i]; #60;
      sclk = 1'b1; #60;
    end
  endtask

  task automatic win_start;
    stb = 1'b0; #60;
  endtask

  task automatic win_end;
    #40 stb = 1'b1; #100;
  endtask

  task automatic win1(input logic [7:0] c);
    win_start; send_bits(c, 8); win_end;
  endtask

  task automatic read_byte(output logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; #60;
      d[i] = dio_out;
      sclk = 1'b1; #60;
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    ram_raddr = a;
    @(negedge clk); @(negedge clk);
    d = ram_rdata;
  endtask

  task automatic chk_ram(input string tag, input logic [3:0] a, input logic [7:0] e);
    logic [7:0] d;
    rd(a, d);
    chk(tag, {24'h0, d}, {24'h0, e});
  endtask

  initial begin
    rst = 1'b0; sclk = 1'b1; stb = 1'b1; dio_in = 1'b1; key_in = '0; ram_raddr = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1; #100;
    // activity, then reset in the middle of a window
    win1(8'h8F);
    chk("pre_disp_on", {31'h0, display_on}, 32'd1);
    win_start; send_bits(8'hC0, 8); send_bits(8'h55, 8); win_end;
    chk_ram("pre_ram0", 4'd0, 8'h55);
    win_start; send_bits(8'hC3, 8); send_bits(8'h77, 3);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_dio_out", {31'h0, dio_out}, 32'd1);
    chk("rst_dio_oe", {31'h0, dio_oe}, 32'd0);
    chk("rst_disp_on", {31'h0, display_on}, 32'd0);
    chk("rst_bright", {29'h0, brightness}, 32'd0);
    chk("rst_rdata", {24'h0, ram_rdata}, 32'd0);
    chk("rst_frame", {31'h0, frame_done}, 32'd0);
    rst = 1'b1;
    for (int a = 0; a < 16; a++) chk_ram("rst_ram", a[3:0], 8'h00);
    base = fd_cnt;
    send_bits(8'h0E, 5); win_end;
    chk("rst_abandon_frame", fd_cnt - base, 32'd0);
    chk_ram("rst_abandon_ram3", 4'd3, 8'h00);
    // auto-increment write
    base = fd_cnt;
    win1(8'h40);
    win_start; send_bits(8'hC0, 8); send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8); win_end;
    chk_ram("auto_ram0", 4'd0, 8'h11);
    chk_ram("auto_ram1", 4'd1, 8'h22);
    chk_ram("auto_ram2", 4'd2, 8'h33);
    chk_ram("auto_ram3", 4'd3, 8'h00);
    chk("auto_frame", fd_cnt - base, 32'd1);
    // fixed address, then auto wrap 15 -> 0
    win1(8'h44);
    win_start; send_bits(8'hCF, 8); send_bits(8'hAA, 8); send_bits(8'hBB, 8); win_end;
    chk_ram("fixed_ram15", 4'd15, 8'hBB);
    chk_ram("fixed_ram0", 4'd0, 8'h11);
    win1(8'h40);
    win_start; send_bits(8'hCF, 8); send_bits(8'h01, 8); send_bits(8'h02, 8); win_end;
    chk_ram("wrap_ram15", 4'd15, 8'h01);
    chk_ram("wrap_ram0", 4'd0, 8'h02);
    // display control
    base = fd_cnt;
    win1(8'h8D);
    chk("disp_on", {31'h0, display_on}, 32'd1);
    chk("disp_bright", {29'h0, brightness}, 32'd5);
    win1(8'h80);
    chk("disp_off", {31'h0, display_on}, 32'd0);
    chk("disp_bright0", {29'h0, brightness}, 32'd0);
    chk("disp_frame", fd_cnt - base, 32'd0);
    // key read with key_in changing mid-read
    key_in = 32'h04030201;
    win_start; send_bits(8'h42, 8);
    chk("read_oe_before", {31'h0, dio_oe}, 32'd0);
    read_byte(v);
    chk("read_b0", {24'h0, v}, 32'h01);
    chk("read_oe_during", {31'h0, dio_oe}, 32'd1);
    key_in = 32'hFFFFFFFF;
    read_byte(v); chk("read_b1", {24'h0, v}, 32'h02);
    read_byte(v); chk("read_b2", {24'h0, v}, 32'h03);
    read_byte(v); chk("read_b3", {24'h0, v}, 32'h04);
    read_byte(v); chk("read_past_end", {24'h0, v}, 32'h00);
    chk("read_oe_end", {31'h0, dio_oe}, 32'd1);
    win_end;
    chk("read_oe_after", {31'h0, dio_oe}, 32'd0);
    // abort mid payload, then a clean transaction
    base = fd_cnt;
    win_start; send_bits(8'hC5, 8); send_bits(8'h99, 5); win_end;
    chk_ram("abort_ram5", 4'd5, 8'h00);
    chk("abort_frame", fd_cnt - base, 32'd0);
    win_start; send_bits(8'hC5, 8); send_bits(8'h99, 8); win_end;
    chk_ram("after_ram5", 4'd5, 8'h99);
    chk_ram("after_ram6", 4'd6, 8'h00);
    chk("after_frame", fd_cnt - base, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
